// File: rtl/pulse_seq_ctrl_pkg.sv
// Shared types and timing constants for the pulse sequencer.
package pulse_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_GAP,
        S_FIN
    } state_t;

    localparam int LOAD_CYC  = 4;
    localparam int FIRE_TAIL = 3;

endpackage

// File: rtl/pulse_seq_ctrl_cnt.sv
// Loadable down counter that stops at 1 and flags terminal count.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && r_cnt > W'(1)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Sequences width loads and FIRE/GAP windows for a downstream pulse-gate stage.
module pulse_seq_ctrl
    import pulse_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      cfg_width,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [PER_W-1:0] cfg_period,
    output logic [15:0]      width_data,
    output logic             width_load,
    output logic             pulse_arm_n,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] rep_done
);

    // FIRE length can reach 63+3, so the shared counter needs at least 7 bits
    localparam int CW = (PER_W > 7) ? PER_W : 7;

    state_t           r_state;
    state_t           w_nxt;
    logic [1:0]       r_ld_cnt;
    logic [1:0]       w_ld_nxt;
    logic [CNT_W-1:0] r_cfg_count;
    logic [PER_W-1:0] r_cfg_period;
    logic             w_latch;
    logic             w_done;
    logic             w_abort;
    logic             w_rep_inc;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic             w_cnt_tc;
    logic [CW-1:0]    w_cnt_val;
    logic [CW-1:0]    w_fire_len;
    logic [CW-1:0]    w_gap_len;

    assign w_fire_len = CW'(width_data[15:10]) + CW'(FIRE_TAIL);
    assign w_gap_len  = (r_cfg_period == '0) ? CW'(1) : CW'(r_cfg_period);
    assign w_cnt_en   = (r_state == S_FIRE) || (r_state == S_GAP);

    seq_down_counter #(
        .W(CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_load(w_cnt_load),
        .i_en  (w_cnt_en),
        .i_val (w_cnt_val),
        .o_tc  (w_cnt_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt      = r_state;
        w_ld_nxt   = r_ld_cnt;
        w_latch    = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        w_rep_inc  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_val  = w_fire_len;
        if (abort && r_state != S_IDLE) begin
            w_nxt   = S_IDLE;
            w_abort = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_count != '0) begin
                            w_latch  = 1'b1;
                            w_ld_nxt = '0;
                            w_nxt    = S_LOAD;
                        end else begin
                            w_done = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    w_ld_nxt = r_ld_cnt + 2'd1;
                    if (r_ld_cnt == 2'(LOAD_CYC - 1)) begin
                        w_nxt      = S_FIRE;
                        w_cnt_load = 1'b1;
                    end
                end
                S_FIRE: begin
                    if (w_cnt_tc) begin
                        w_nxt      = S_GAP;
                        w_rep_inc  = 1'b1;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = w_gap_len;
                    end
                end
                S_GAP: begin
                    if (w_cnt_tc) begin
                        if (rep_done == r_cfg_count) begin
                            w_nxt  = S_FIN;
                            w_done = 1'b1;
                        end else begin
                            w_nxt      = S_FIRE;
                            w_cnt_load = 1'b1;
                        end
                    end
                end
                S_FIN: w_nxt = S_IDLE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_cnt     <= '0;
            r_cfg_count  <= '0;
            r_cfg_period <= '0;
            width_data   <= '0;
            width_load   <= 1'b0;
            pulse_arm_n  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            rep_done     <= '0;
        end else begin
            r_ld_cnt    <= w_ld_nxt;
            width_load  <= (w_nxt == S_LOAD) && !w_ld_nxt[0];
            pulse_arm_n <= (w_nxt == S_FIRE);
            busy        <= (w_nxt != S_IDLE);
            done        <= w_done;
            aborted     <= w_abort;
            if (w_latch) begin
                width_data   <= cfg_width;
                r_cfg_count  <= cfg_count;
                r_cfg_period <= cfg_period;
            end
            if (w_latch) begin
                rep_done <= '0;
            end else if (w_rep_inc && rep_done != '1) begin
                rep_done <= rep_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench with a schedule-based reference model for pulse_seq_ctrl.
module tb_pulse_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_width = '0;
    logic [7:0]  cfg_count = '0;
    logic [15:0] cfg_period = '0;
    logic [15:0] width_data;
    logic        width_load;
    logic        pulse_arm_n;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  rep_done;

    pulse_seq_ctrl #(.CNT_W(8), .PER_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_width  (cfg_width),
        .cfg_count  (cfg_count),
        .cfg_period (cfg_period),
        .width_data (width_data),
        .width_load (width_load),
        .pulse_arm_n(pulse_arm_n),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .rep_done   (rep_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        arm;
        logic        ld;
        logic        bsy;
        logic        dn;
        logic        ab;
        logic [7:0]  rep;
        logic [15:0] wd;
    } rec_t;

    rec_t cur = '0;
    rec_t act;
    rec_t q[$];

    int checks = 0;
    int failures = 0;
    int n_load, n_arm, n_rise, n_gap, n_done, n_abort;
    logic prev_arm = 1'b0;

    function automatic rec_t mk(logic arm, logic ld, logic bsy, logic dn,
                                logic ab, logic [7:0] rep, logic [15:0] wd);
        rec_t r;
        r.arm = arm; r.ld = ld; r.bsy = bsy; r.dn = dn;
        r.ab = ab; r.rep = rep; r.wd = wd;
        return r;
    endfunction

    // Expand a whole accepted sequence into the per-cycle output schedule
    task automatic build(input logic [15:0] w, input int c, input int p);
        int fl = int'(w[15:10]) + 3;
        int gl = (p == 0) ? 1 : p;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(mk(0, (i % 2) == 0, 1, 0, 0, 8'd0, w));
        for (int n = 1; n <= c; n++) begin
            for (int i = 0; i < fl; i++) q.push_back(mk(1, 0, 1, 0, 0, 8'(n - 1), w));
            for (int i = 0; i < gl; i++) q.push_back(mk(0, 0, 1, 0, 0, 8'(n), w));
        end
        q.push_back(mk(0, 0, 1, 1, 0, 8'(c), w));
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            cur = '0;
        end else if (cur.bsy) begin
            if (abort) begin
                q.delete();
                cur = mk(0, 0, 0, 0, 1, cur.rep, cur.wd);
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = mk(0, 0, 0, 0, 0, cur.rep, cur.wd);
            end
        end else if (start && cfg_count != 0) begin
            build(cfg_width, int'(cfg_count), int'(cfg_period));
            cur = q.pop_front();
        end else begin
            cur = mk(0, 0, 0, start, 0, cur.rep, cur.wd);
        end
    end

    always @(negedge clk) begin
        act = {pulse_arm_n, width_load, busy, done, aborted, rep_done, width_data};
        checks++;
        if (act !== cur) begin
            failures++;
            $display("FAIL model t=%0t got arm%b ld%b bsy%b dn%b ab%b rep%0d wd%h exp arm%b ld%b bsy%b dn%b ab%b rep%0d wd%h",
                     $time, act.arm, act.ld, act.bsy, act.dn, act.ab, act.rep, act.wd,
                     cur.arm, cur.ld, cur.bsy, cur.dn, cur.ab, cur.rep, cur.wd);
        end
        n_load  += int'(width_load);
        n_arm   += int'(pulse_arm_n);
        n_done  += int'(done);
        n_abort += int'(aborted);
        if (busy && !pulse_arm_n && !done && n_rise > 0) n_gap++;
        if (pulse_arm_n && !prev_arm) n_rise++;
        prev_arm = pulse_arm_n;
    end

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic clr();
        n_load = 0; n_arm = 0; n_rise = 0; n_gap = 0; n_done = 0; n_abort = 0;
    endtask

    task automatic go(input logic [15:0] w, input logic [7:0] c, input logic [15:0] p);
        cfg_width = w; cfg_count = c; cfg_period = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && n_done == 0 && n_abort == 0; i++) begin
            @(negedge clk); #1;
        end
        check("wait_end", n_done + n_abort, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_arm", int'(pulse_arm_n), 0);
        check("rst_rep", int'(rep_done), 0);
        check("rst_wd", int'(width_data), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        clr();
        go(16'h0C53, 8'd1, 16'd10);
        @(negedge clk); #1;
        check("first_start", int'(busy), 1);
        wait_done(60);
        check("t1_loads", n_load, 2);
        check("t1_arm", n_arm, 6);
        check("t1_gap", n_gap, 10);
        check("t1_done", n_done, 1);
        check("t1_rep", int'(rep_done), 1);

        clr();
        go(16'h0000, 8'd3, 16'd0);
        wait_done(80);
        check("t2_rises", n_rise, 3);
        check("t2_arm", n_arm, 9);
        check("t2_loads", n_load, 2);
        check("t2_gap", n_gap, 3);
        check("t2_rep", int'(rep_done), 3);

        clr();
        go(16'h1234, 8'd0, 16'd5);
        @(negedge clk); #1;
        check("z_done", int'(done), 1);
        check("z_busy", int'(busy), 0);
        check("z_arm", int'(pulse_arm_n), 0);
        @(negedge clk); #1;
        check("z_done_once", n_done, 1);

        clr();
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk); #1;
        check("idle_abort", n_abort, 0);

        clr();
        @(posedge clk); #1;
        cfg_width = 16'h0800; cfg_count = 8'd5; cfg_period = 16'd4;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk); #1;
        check("start_wins", int'(busy), 1);
        for (int i = 0; i < 200 && n_rise < 2; i++) begin
            @(negedge clk); #1;
        end
        check("ab_reach", n_rise, 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk); #1;
        check("ab_arm", int'(pulse_arm_n), 0);
        check("ab_pulse", int'(aborted), 1);
        repeat (5) @(negedge clk);
        #1;
        check("ab_once", n_abort, 1);
        check("ab_nodone", n_done, 0);
        check("ab_rep", int'(rep_done), 1);

        clr();
        @(posedge clk); #1;
        go(16'h0C53, 8'd2, 16'd3);
        for (int i = 0; i < 50 && !pulse_arm_n; i++) begin
            @(negedge clk); #1;
        end
        check("rs_fire", int'(pulse_arm_n), 1);
        #2 reset = 1'b0;
        #1;
        check("rs_arm_async", int'(pulse_arm_n), 0);
        check("rs_busy", int'(busy), 0);
        check("rs_rep", int'(rep_done), 0);
        check("rs_wd", int'(width_data), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        clr();
        go(16'h0C53, 8'd1, 16'd10);
        wait_done(60);
        check("rs_arm", n_arm, 6);
        check("rs_rep_after", int'(rep_done), 1);

        clr();
        go(16'h0C53, 8'd2, 16'd5);
        for (int i = 0; i < 80 && n_gap < 1; i++) begin
            @(negedge clk); #1;
        end
        check("ig_gap_seen", n_gap, 1);
        @(posedge clk); #1;
        start = 1'b1;
        cfg_width = 16'hFFFF; cfg_count = 8'd7; cfg_period = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        check("ig_arm", n_arm, 12);
        check("ig_rises", n_rise, 2);
        check("ig_gap", n_gap, 10);
        check("ig_loads", n_load, 2);
        check("ig_wd", int'(width_data), 16'h0C53);
        check("ig_rep", int'(rep_done), 2);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
